// File: rtl/vga_stream_timing.sv
// VGA timing generator and show-ahead-off FIFO pixel reader (8-bit grey or RGB565).
// Define VGA_TPG_EN to add the tpg_sel input and an 8-bar colour test pattern.
module vga_stream_timing #(
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 192,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 64,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 20,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int SYNC_POL = 0,
    parameter int DATA_W   = 8
) (
    input  logic              vga_clk,
    input  logic              rstn,
`ifdef VGA_TPG_EN
    input  logic              tpg_sel,
`endif
    input  logic [DATA_W-1:0] rfifo_data,
    input  logic              rfifo_empty,
    output logic              rfifo_req,
    output logic              rfifo_clr,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [4:0]        vga_r,
    output logic [5:0]        vga_g,
    output logic [4:0]        vga_b,
    output logic              frame_start,
    output logic              underflow,
    output logic [15:0]       uf_count
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int H_DE0 = H_SYNC + H_BP;
    localparam int H_DE1 = H_DE0 + H_ACTIVE;
    localparam int V_DE0 = V_SYNC + V_BP;
    localparam int V_DE1 = V_DE0 + V_ACTIVE;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    generate
        if (DATA_W != 8 && DATA_W != 16) begin : g_bad_width
            $error("vga_stream_timing: DATA_W must be 8 or 16, got %0d", DATA_W);
        end
    endgenerate

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_ERR} state_t;

    state_t        state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, v_wrap, de_raw, hs_raw, vs_raw, fs_raw, arm_pt;
    logic          tpg_on, vld_p1;
    logic [4:0]    tpg_r_p1, tpg_b_p1, pix_r, pix_b;
    logic [5:0]    tpg_g_p1, pix_g;

    always_comb begin
        h_wrap = (int'(h_cnt) == H_TOT - 1);
        v_wrap = (int'(v_cnt) == V_TOT - 1);
        de_raw = (int'(h_cnt) >= H_DE0) && (int'(h_cnt) < H_DE1) &&
                 (int'(v_cnt) >= V_DE0) && (int'(v_cnt) < V_DE1);
        hs_raw = (int'(h_cnt) < H_SYNC);
        vs_raw = (int'(v_cnt) < V_SYNC);
        fs_raw = (h_cnt == '0) && (v_cnt == '0);
        arm_pt = (h_cnt == '0) && (int'(v_cnt) == V_DE0);
    end

    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign rfifo_req = de_raw && (state == S_RUN) && !rfifo_empty;

    // Frame-level FSM; frame_start takes priority over a same-cycle underflow.
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_WAIT;
            rfifo_clr <= 1'b0;
            underflow <= 1'b0;
            uf_count  <= '0;
        end else begin
            rfifo_clr <= 1'b0;
            underflow <= 1'b0;
            if (fs_raw) begin
                rfifo_clr <= (state == S_ERR);
                state     <= (arm_pt && !rfifo_empty && !tpg_on) ? S_RUN : S_WAIT;
            end else begin
                case (state)
                    S_WAIT: if (arm_pt && !rfifo_empty && !tpg_on) state <= S_RUN;
                    S_RUN: if (de_raw && rfifo_empty) begin
                        state     <= S_ERR;
                        underflow <= 1'b1;
                        if (uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage p1: syncs and DE delayed one cycle to line up with FIFO read data.
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            vga_hs      <= ~SYNC_ON;
            vga_vs      <= ~SYNC_ON;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vga_hs      <= hs_raw ? SYNC_ON : ~SYNC_ON;
            vga_vs      <= vs_raw ? SYNC_ON : ~SYNC_ON;
            vga_de      <= de_raw;
            frame_start <= fs_raw;
            vld_p1      <= rfifo_req;
        end
    end

`ifdef VGA_TPG_EN
    logic [2:0] bar;
    assign bar = 3'((int'(h_cnt) - H_DE0) / BAR_W);

    // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            tpg_on   <= 1'b0;
            tpg_r_p1 <= '0;
            tpg_g_p1 <= '0;
            tpg_b_p1 <= '0;
        end else begin
            if (fs_raw) tpg_on <= tpg_sel;
            if (tpg_on && de_raw) begin
                tpg_r_p1 <= {5{~bar[1]}};
                tpg_g_p1 <= {6{~bar[2]}};
                tpg_b_p1 <= {5{~bar[0]}};
            end else begin
                tpg_r_p1 <= '0;
                tpg_g_p1 <= '0;
                tpg_b_p1 <= '0;
            end
        end
    end
`else
    assign tpg_on   = 1'b0;
    assign tpg_r_p1 = '0;
    assign tpg_g_p1 = '0;
    assign tpg_b_p1 = '0;
`endif

    generate
        if (DATA_W == 16) begin : g_rgb565
            assign pix_r = rfifo_data[15:11];
            assign pix_g = rfifo_data[10:5];
            assign pix_b = rfifo_data[4:0];
        end else begin : g_grey
            assign pix_r = rfifo_data[7:3];
            assign pix_g = rfifo_data[7:2];
            assign pix_b = rfifo_data[7:3];
        end
    endgenerate

    always_comb begin
        vga_r = tpg_r_p1;
        vga_g = tpg_g_p1;
        vga_b = tpg_b_p1;
        if (vld_p1 && vga_de) begin
            vga_r = pix_r;
            vga_g = pix_g;
            vga_b = pix_b;
        end
    end

endmodule
